// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller.
// Holds one pattern of up to MAXLEN bits, detects it on a gated serial stream in
// overlapping or non-overlapping mode, counts matches and stops at a target count.
module seq_det_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNTW   = 8,
    localparam int unsigned LW    = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    input  logic              x,
    input  logic              x_valid,
    output logic              match,
    output logic [CNTW-1:0]   match_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

    state_e            state_q, state_d;
    logic              loaded_q, loaded_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [LW-1:0]     len_q, len_d;
    logic              ovl_q, ovl_d;
    logic [CNTW-1:0]   tgt_q, tgt_d;
    // Only MAXLEN-1 history bits can ever take part in a compare with the incoming bit.
    logic [MAXLEN-2:0] hist_q, hist_d;
    logic [LW-1:0]     fill_q, fill_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              err_q, err_d;
    logic              ready_q, busy_q, done_q;

    logic [MAXLEN-1:0] shifted;
    logic [MAXLEN-1:0] mask;
    logic              len_ok;
    logic              hit;
    logic [CNTW-1:0]   cnt_inc;

    // Hit detection on the incoming bit against the low len bits of the pattern.
    always_comb begin
        shifted = {hist_q, x};
        for (int i = 0; i < int'(MAXLEN); i++) begin
            mask[i] = (LW'(i) < len_q);
        end
        hit     = ((shifted & mask) == (pat_q & mask)) &&
                  (({1'b0, fill_q} + (LW + 1)'(1)) >= {1'b0, len_q});
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
        len_ok  = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAXLEN));
    end

    // Next-state logic: abort beats start, start beats data sampling.
    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        tgt_d    = tgt_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        match_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    // A config write wins over a simultaneous start.
                    if (len_ok) begin
                        pat_d    = cfg_pattern;
                        len_d    = cfg_len;
                        ovl_d    = cfg_overlap;
                        tgt_d    = cfg_target;
                        loaded_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start && loaded_q) begin
                    state_d = StArmed;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            StArmed: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (x_valid) begin
                    hist_d = shifted[MAXLEN-2:0];
                    fill_d = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + LW'(1);
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StArmed;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            loaded_q <= 1'b0;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            tgt_q    <= '0;
            hist_q   <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            tgt_q    <= tgt_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            err_q    <= err_d;
            ready_q  <= (state_d == StIdle);
            busy_q   <= (state_d == StArmed);
            done_q   <= (state_d == StDone);
        end
    end

    assign cfg_ready   = ready_q;
    assign cfg_err     = err_q;
    assign match       = match_q;
    assign match_count = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model of the detector.
module tb_seq_det_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [7:0]      cfg_pattern = '0;
    logic [3:0]      cfg_len = '0;
    logic            cfg_overlap = 1'b0;
    logic [7:0]      cfg_target = '0;
    logic            cfg_err;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            x = 1'b0;
    logic            x_valid = 1'b0;
    logic            match;
    logic [7:0]      match_count;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 armed, 2 done. The window holds the valid bits seen
    // since arming (or since the last non-overlapping hit).
    int         m_state = 0;
    bit         m_loaded = 0;
    logic [7:0] m_pat = '0;
    int         m_len = 0;
    bit         m_ovl = 0;
    int         m_tgt = 0;
    int         m_cnt = 0;
    bit         m_match = 0;
    bit         m_err = 0;
    bit         win[$];

    seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit win_hit();
        int n;
        n = win.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (win[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model with the current inputs, clock once, then compare all outputs.
    task automatic tick();
        m_match = 0;
        m_err   = 0;
        if (rst) begin
            m_state = 0; m_loaded = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0;
            m_cnt = 0; win.delete();
        end else begin
            case (m_state)
                0: begin
                    if (cfg_valid) begin
                        if (cfg_len >= 2 && cfg_len <= MAXLEN) begin
                            m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap;
                            m_tgt = cfg_target; m_loaded = 1;
                        end else begin
                            m_err = 1;
                        end
                    end else if (start && m_loaded) begin
                        m_state = 1; m_cnt = 0; win.delete();
                    end
                end
                1: begin
                    if (abort) begin
                        m_state = 0;
                    end else if (x_valid) begin
                        win.push_back(x);
                        if (win.size() > MAXLEN) void'(win.pop_front());
                        if (win_hit()) begin
                            m_match = 1;
                            if (m_cnt < 255) m_cnt++;
                            if (!m_ovl) win.delete();
                            if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
                        end
                    end
                end
                default: begin
                    if (abort) m_state = 0;
                    else if (start) begin
                        m_state = 1; m_cnt = 0; win.delete();
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        chk("match", match, m_match);
        chk("match_count", match_count, m_cnt);
        chk("cfg_err", cfg_err, m_err);
        chk("cfg_ready", cfg_ready, m_state == 0);
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
    endtask

    task automatic write_cfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                             input logic [7:0] t);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_valid = 1;
        tick();
        cfg_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic pulse_abort();
        abort = 1; tick(); abort = 0;
    endtask

    task automatic send(input bit b, input bit v);
        x = b; x_valid = v; tick(); x_valid = 0;
    endtask

    initial begin
        // Reset state
        rst = 1; tick(); rst = 0;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_count", match_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Start with no configuration is ignored
        pulse_start();
        chk("nocfg_start_idle", cfg_ready, 1);

        // Overlapping 1010
        write_cfg(8'b0000_1010, 4'd4, 1'b1, 8'd0);
        pulse_start();
        send(1, 1); send(0, 1); send(1, 1); send(0, 1);
        chk("ovl_first_match", match, 1);
        send(1, 1); send(0, 1);
        chk("ovl_second_match", match, 1);
        send(0, 1);
        chk("ovl_count", match_count, 2);
        chk("ovl_armed", busy, 1);

        // Non-overlapping 1010
        pulse_abort();
        chk("abort_keeps_count", match_count, 2);
        write_cfg(8'b0000_1010, 4'd4, 1'b0, 8'd0);
        pulse_start();
        send(1, 1); send(0, 1); send(1, 1); send(0, 1); send(1, 1); send(0, 1); send(0, 1);
        chk("novl_count", match_count, 1);

        // Target 3 with pattern 11
        pulse_abort();
        write_cfg(8'b0000_0011, 4'd2, 1'b1, 8'd3);
        pulse_start();
        for (int i = 0; i < 4; i++) send(1, 1);
        chk("tgt_done", done, 1);
        chk("tgt_busy", busy, 0);
        chk("tgt_count", match_count, 3);
        send(1, 1);
        chk("tgt_frozen", match_count, 3);
        chk("tgt_nomatch", match, 0);
        start = 1; abort = 0; tick(); start = 0;
        chk("rearm_count", match_count, 0);
        chk("rearm_busy", busy, 1);

        // Rejected configurations keep the 11 pattern
        pulse_abort();
        write_cfg(8'hFF, 4'd9, 1'b0, 8'd0);
        chk("len9_err", cfg_err, 1);
        tick();
        chk("len9_err_pulse", cfg_err, 0);
        write_cfg(8'hFF, 4'd1, 1'b0, 8'd0);
        chk("len1_err", cfg_err, 1);
        pulse_start();
        send(1, 1); send(1, 1);
        chk("kept_cfg_match", match, 1);

        // Gaps inside 1010
        pulse_abort();
        write_cfg(8'b0000_1010, 4'd4, 1'b1, 8'd0);
        pulse_start();
        send(1, 1); send(0, 0); send(0, 1); send(1, 0); send(0, 0); send(1, 1); send(0, 1);
        chk("gap_match", match, 1);
        chk("gap_count", match_count, 1);

        // Abort on the completing edge drops the match
        pulse_abort();
        pulse_start();
        send(1, 1); send(0, 1); send(1, 1);
        x = 0; x_valid = 1; abort = 1; tick(); x_valid = 0; abort = 0;
        chk("abort_edge_nomatch", match, 0);
        chk("abort_edge_idle", cfg_ready, 1);

        // abort + start together in ARMED
        pulse_start();
        abort = 1; start = 1; tick(); abort = 0; start = 0;
        chk("abort_start_idle", cfg_ready, 1);

        // Reset mid-run
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send(1, 1); send(0, 1);
        end
        chk("pre_rst_count", match_count, 2);
        rst = 1; tick(); rst = 0;
        chk("midrst_count", match_count, 0);
        chk("midrst_ready", cfg_ready, 1);
        pulse_start();
        chk("midrst_start_ignored", busy, 0);

        // Randomized traffic
        for (int run = 0; run < 40; run++) begin
            if (!cfg_ready) pulse_abort();
            write_cfg(8'($urandom), 4'($urandom_range(1, 9)), 1'($urandom),
                      8'($urandom_range(0, 4)));
            pulse_start();
            for (int c = 0; c < 60; c++) begin
                x         = 1'($urandom);
                x_valid   = ($urandom_range(0, 3) != 0);
                abort     = ($urandom_range(0, 49) == 0);
                start     = ($urandom_range(0, 29) == 0);
                cfg_valid = ($urandom_range(0, 19) == 0);
                cfg_len   = 4'($urandom_range(1, 9));
                cfg_pattern = 8'($urandom);
                rst       = ($urandom_range(0, 99) == 0);
                tick();
            end
            x_valid = 0; abort = 0; start = 0; cfg_valid = 0; rst = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detection controller for the FSM block family. It holds one configurable bit pattern of up to MAXLEN bits, selectable overlapping or non-overlapping detection, and a match target. A host writes the configuration, then arms, monitors, counts and completes the detection run. It replaces the per-pattern hard-coded Mealy detectors with a single configurable unit driven by a cfg/start/abort interface.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
CNTW, 8, width of match counter and target

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  configuration write request
cfg_ready  out  1  high only in IDLE; configuration accepted on cfg_valid & cfg_ready
cfg_pattern  in  MAXLEN  pattern; bit [len-1] is the first serial bit, bit 0 the last
cfg_len  in  $clog2(MAXLEN+1)  pattern length in bits
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNTW  number of matches that ends the run; 0 = free-run
cfg_err  out  1  one-cycle pulse when a configuration write is rejected
start  in  1  arm or re-arm the detector
abort  in  1  return to IDLE
x  in  1  serial data bit
x_valid  in  1  x is sampled only when high
match  out  1  one-cycle pulse per detected pattern
match_count  out  CNTW  matches counted in the current run
busy  out  1  high in ARMED
done  out  1  high in DONE

Behaviour:
- Reset, any state: state=IDLE; cfg_loaded=0; pattern, len, overlap and target registers cleared; history=0; fill=0; match=0; match_count=0; cfg_err=0; busy=0; done=0; cfg_ready=1.
- States: IDLE, ARMED, DONE. Encoding is free. All outputs are registered.
- IDLE:
  - On cfg_valid: if 2 <= cfg_len <= MAXLEN, latch all cfg_* fields and set cfg_loaded=1. Otherwise assert cfg_err for 1 cycle and leave the stored configuration unchanged.
  - start with cfg_loaded=1 -> ARMED, clear history, fill and match_count.
  - start with cfg_loaded=0 is ignored.
  - If cfg_valid and start are both high, the new configuration is latched this cycle and start is ignored.
- ARMED (busy=1):
  - Each x_valid cycle: history <= {history[MAXLEN-2:0], x}; fill <= min(fill+1, MAXLEN).
  - A hit is detected combinationally on the incoming bit: ({history, x} low len bits == pattern low len bits) and fill+1 >= len.
  - On a hit, match pulses 1 in the next cycle and match_count increments, saturating at all-ones.
  - Overlapping mode: history and fill are unchanged by a hit.
  - Non-overlapping mode: fill <= 0 on a hit, so the next match needs len fresh bits.
  - If target != 0 and the incremented count == target -> DONE in the same edge.
  - Cycles with x_valid=0 shift nothing and leave state unchanged.
- DONE (done=1, held):
  - Further x is ignored; match_count is frozen.
  - start -> ARMED with count, history and fill cleared.
- abort in ARMED or DONE -> IDLE next cycle; configuration is kept, match_count is kept for readout, and a match pending on that same edge is dropped.
- Priority: rst > abort > start > data sampling.
- A start in ARMED is ignored; it does not re-arm.
- cfg_valid outside IDLE is ignored: cfg_ready=0 and no cfg_err.
- Reset mid-run forces IDLE and clears the configuration, so a new cfg write is required.

Test Plan:
- Overlap: cfg pattern=4'b1010, len=4, overlap=1, target=0; start; stream x=1,0,1,0,1,0,0 (x_valid=1) -> match pulses after the 4th and 6th bits; match_count=2; state stays ARMED.
- Non-overlap: same stream with overlap=0 -> a single match after the 4th bit; match_count=1.
- Target and done: pattern 2'b11, len=2, overlap=1, target=3; stream 1,1,1,1,1 -> count reaches 3 on the 4th bit; done=1, busy=0; the 5th bit produces no match and count stays 3; a later start clears count to 0 and sets busy=1.
- Config error: cfg_len=9 with MAXLEN=8 -> cfg_err pulses 1 cycle and the previous configuration is retained; cfg_len=1 -> same result; start before any valid cfg -> stays IDLE.
- Gaps, abort and simultaneous events: insert x_valid=0 cycles inside 1,0,1,0 -> match still occurs after the last valid bit. Abort on the edge that completes a pattern -> no match pulse and IDLE next cycle. abort+start together -> IDLE.
- Reset mid-run: rst=1 for 1 cycle during ARMED with count=2 -> count=0, IDLE, cfg_loaded=0, cfg_ready=1; a subsequent start is ignored.
